morse_sequence_player: RTL and testbench
========================================

Name: morse_sequence_player

Overview:
- Playback (transmit) end of the Morse translator.
- Consumes the FirstSeq/SecSeq pair produced by the sequence separator and serialises it into on/off keying with standard Morse timing.
- The key output drives the LED/buzzer.
- Timing is in units of UNIT_CYCLES clocks. One load plays FirstSeq then SecSeq, then pulses done.

Parameters:
- UNIT_CYCLES, 25000000, clocks per Morse time unit (dot length); must be ≥2.
- CNT_W, 25, width of unit counter; must hold UNIT_CYCLES-1.

Ports:
- clk  in  1  system clock, rising-edge.
- resetbar  in  1  asynchronous active-low reset.
- sentFlag  in  1  load request from separator (level); sampled on its rising edge.
- FirstSeq  in  10  first encoded sequence.
- SecSeq  in  10  second encoded sequence.
- key  out  1  keying output, 1 = tone/light on.
- busy  out  1  high from load until done.
- done  out  1  one-cycle pulse when playback completes.

Behaviour:
- Encoding: 5 two-bit symbols per sequence, MSB pair first. 00 = dot, 01 = dash, 10 = word space, 11 = empty/terminator.
- Reset (resetbar low, async): key=0, busy=0, done=0, state IDLE, shift register all 1s, sentFlag edge register=0. This also applies when reset is asserted mid-playback; no residual gap is played after release.
- Load: in IDLE, when sentFlag is sampled 1 and its registered previous value is 0, latch {FirstSeq,SecSeq} into a 20-bit register and set busy=1 at that same edge.
  - sentFlag held high gives exactly one load.
  - Rising edges while busy are ignored; a new edge is needed after done.
- States: IDLE, FETCH, MARK, GAP, WORD, DONE.
- FETCH: 1 cycle. Decodes the current symbol of the current sequence (5 symbols per sequence, index 0..4).
  - 00 → MARK, 1 unit.
  - 01 → MARK, 3 units.
  - 10 → WORD.
  - 11, or index past 4 → end of sequence. Advance to SecSeq, or to DONE if already in SecSeq. No gap is emitted for the sequence end itself.
- MARK: key=1 for exactly N×UNIT_CYCLES clocks. The unit counter restarts at 0 on entry to every timed state.
- GAP after a mark (key=0):
  - 1 unit if the next symbol in the same sequence is 00/01.
  - 0 units if the next symbol is 10.
  - Otherwise 3 units (letter gap). Set the letter_gap flag.
  - Then return to FETCH on the next symbol.
- WORD: key=0.
  - 4 units if letter_gap flag is set, else 7 units. Total inter-word silence is therefore 7 units.
  - Clears letter_gap.
  - Terminates the current sequence; remaining symbols are ignored.
- FETCH cycles add 1 clock of key=0 each. Mark lengths are exact; gap lengths are exact plus FETCH overhead.
- letter_gap is cleared on load and by any MARK.
- A sequence with 11 in its MSB pair is skipped. If both sequences are empty, go straight to DONE with no key activity.
- DONE: 1 cycle. done=1, busy=0 on exit, return to IDLE.
- First key assertion: 2 clocks after the load edge (load edge → FETCH → MARK).

Test Plan:
- UNIT_CYCLES=4. FirstSeq=10'b0001111111 ("A"), SecSeq=10'b1111111111, rising edge of sentFlag.
  - Required: key high 4, low 4+1, high 12, low 12 (letter gap) + FETCH cycles.
  - Then done pulses once and busy falls.
- FirstSeq=10'b1011111111 (space), SecSeq=all 1s → key stays 0, 28 clocks of WORD silence, done pulses.
- FirstSeq=10'b0011111111 ("E"), SecSeq=10'b1011111111 (space) → key high 4, then low 12 + 16 (letter gap + reduced word gap), done.
- FirstSeq=10'b0101010101 ("0"), SecSeq=all 1s → five 12-clock marks separated by 4-clock gaps, then 12-clock letter gap.
- Both sequences all 1s → no key activity, done within 4 clocks. sentFlag held high 100 clocks → exactly one done pulse.
- Reset mid-dash: resetbar low for 1 clock → key, busy, done all 0 immediately (async). Release, then pulse sentFlag → playback starts cleanly from symbol 0.

Source files
------------

// File: rtl/morse_sequence_player.sv
// Morse playback engine: serialises a FirstSeq/SecSeq pair of 2-bit symbols
// into on/off keying with standard Morse unit timing, then pulses done.
module morse_sequence_player #(
  parameter int unsigned UNIT_CYCLES = 25000000,
  parameter int unsigned CNT_W       = 25
) (
  input  logic       clk,
  input  logic       resetbar,
  input  logic       sentFlag,
  input  logic [9:0] FirstSeq,
  input  logic [9:0] SecSeq,
  output logic       key,
  output logic       busy,
  output logic       done
);

  typedef enum logic [2:0] {IDLE, FETCH, MARK, GAP, WORD, DONE} state_t;

  localparam logic [CNT_W-1:0] UNIT_LAST = CNT_W'(UNIT_CYCLES - 1);
  localparam logic [2:0]       IDX_END   = 3'd5;

  state_t           state, stateNext;
  logic [19:0]      seqReg, seqRegNext;
  logic             seqSel, seqSelNext;
  logic [2:0]       symIdx, symIdxNext;
  logic [CNT_W-1:0] unitCnt, unitCntNext;
  logic [2:0]       unitsLeft, unitsLeftNext;
  logic             letterGap, letterGapNext;
  logic             sentPrev;
  logic             load;
  logic             timerDone;
  logic [9:0]       curSeq;
  logic [1:0]       curSym;

  // Indices past the last symbol read as the terminator.
  function automatic logic [1:0] symAt(input logic [9:0] s, input logic [2:0] i);
    case (i)
      3'd0:    symAt = s[9:8];
      3'd1:    symAt = s[7:6];
      3'd2:    symAt = s[5:4];
      3'd3:    symAt = s[3:2];
      3'd4:    symAt = s[1:0];
      default: symAt = 2'b11;
    endcase
  endfunction

  assign curSeq    = seqSel ? seqReg[9:0] : seqReg[19:10];
  assign curSym    = symAt(curSeq, symIdx);
  assign load      = (state == IDLE) && sentFlag && !sentPrev;
  assign timerDone = (unitCnt == UNIT_LAST) && (unitsLeft == 3'd1);

  assign key  = (state == MARK);
  assign busy = (state != IDLE);
  assign done = (state == DONE);

  // NOTE: every variable gets a default before the case so no latch is inferred.
  always_comb begin
    stateNext     = state;
    seqRegNext    = seqReg;
    seqSelNext    = seqSel;
    symIdxNext    = symIdx;
    unitCntNext   = unitCnt;
    unitsLeftNext = unitsLeft;
    letterGapNext = letterGap;

    if (state == MARK || state == GAP || state == WORD) begin
      if (unitCnt == UNIT_LAST) begin
        unitCntNext   = '0;
        unitsLeftNext = unitsLeft - 3'd1;
      end else begin
        unitCntNext = unitCnt + CNT_W'(1);
      end
    end

    case (state)
      IDLE: begin
        if (load) begin
          seqRegNext    = {FirstSeq, SecSeq};
          seqSelNext    = 1'b0;
          symIdxNext    = '0;
          letterGapNext = 1'b0;
          stateNext     = FETCH;
        end
      end
      FETCH: begin
        unitCntNext = '0;
        case (curSym)
          2'b00, 2'b01: begin
            stateNext     = MARK;
            unitsLeftNext = (curSym == 2'b01) ? 3'd3 : 3'd1;
            symIdxNext    = symIdx + 3'd1;
          end
          2'b10: begin
            // The word gap absorbs a preceding letter gap so silence totals 7 units.
            stateNext     = WORD;
            unitsLeftNext = letterGap ? 3'd4 : 3'd7;
            letterGapNext = 1'b0;
            symIdxNext    = IDX_END;
          end
          default: begin
            if (!seqSel) begin
              seqSelNext = 1'b1;
              symIdxNext = '0;
            end else begin
              stateNext = DONE;
            end
          end
        endcase
      end
      MARK: begin
        letterGapNext = 1'b0;
        if (timerDone) begin
          unitCntNext = '0;
          // symIdx already points at the following symbol, which sets the gap.
          case (curSym)
            2'b00, 2'b01: begin
              stateNext     = GAP;
              unitsLeftNext = 3'd1;
            end
            2'b10:   stateNext = FETCH;
            default: begin
              stateNext     = GAP;
              unitsLeftNext = 3'd3;
              letterGapNext = 1'b1;
            end
          endcase
        end
      end
      GAP, WORD: begin
        if (timerDone) stateNext = FETCH;
      end
      DONE:    stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk or negedge resetbar) begin
    if (!resetbar) begin
      state     <= IDLE;
      seqReg    <= '1;
      seqSel    <= 1'b0;
      symIdx    <= '0;
      unitCnt   <= '0;
      unitsLeft <= '0;
      letterGap <= 1'b0;
      sentPrev  <= 1'b0;
    end else begin
      state     <= stateNext;
      seqReg    <= seqRegNext;
      seqSel    <= seqSelNext;
      symIdx    <= symIdxNext;
      unitCnt   <= unitCntNext;
      unitsLeft <= unitsLeftNext;
      letterGap <= letterGapNext;
      sentPrev  <= sentFlag;
    end
  end

endmodule

// File: tb/tb_morse_sequence_player.sv
// Scoreboard bench: a timeline model of Morse playback queues the expected
// per-cycle key trace; a monitor compares what the DUT plays at each done.
module tb_morse_sequence_player;

  localparam int U = 4;

  logic       clk = 1'b0;
  logic       resetbar = 1'b0;
  logic       sentFlag = 1'b0;
  logic [9:0] FirstSeq = '0;
  logic [9:0] SecSeq = '0;
  logic       key, busy, done;

  int vectors = 0;
  int miscompares = 0;
  int doneCount = 0;

  bit expBits[$];
  int expLen[$];
  bit monTl[$];

  morse_sequence_player #(.UNIT_CYCLES(U), .CNT_W(3)) dut (
    .clk(clk), .resetbar(resetbar), .sentFlag(sentFlag),
    .FirstSeq(FirstSeq), .SecSeq(SecSeq),
    .key(key), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int symOf(input logic [9:0] sq, input int i);
    logic [9:0] t;
    if (i > 4) return 3;
    t = sq >> (8 - 2 * i);
    return int'(t[1:0]);
  endfunction

  // Expected key level for every busy cycle, from the first decode to the done cycle.
  task automatic expectPlay(input logic [9:0] f, input logic [9:0] s);
    bit tl[$];
    logic [9:0] sq;
    int sym, nxt, i;
    bit lg;
    lg = 0;
    for (int k = 0; k < 2; k++) begin
      sq = (k == 0) ? f : s;
      i = 0;
      while (1) begin
        sym = symOf(sq, i);
        tl.push_back(1'b0);
        if (sym == 3) break;
        if (sym == 2) begin
          repeat ((lg ? 4 : 7) * U) tl.push_back(1'b0);
          lg = 0;
          i = 5;
        end else begin
          repeat ((sym == 1 ? 3 : 1) * U) tl.push_back(1'b1);
          lg = 0;
          i++;
          nxt = symOf(sq, i);
          if (nxt < 2) repeat (U) tl.push_back(1'b0);
          else if (nxt == 3) begin
            repeat (3 * U) tl.push_back(1'b0);
            lg = 1;
          end
        end
      end
    end
    tl.push_back(1'b0);
    expLen.push_back(tl.size());
    foreach (tl[j]) expBits.push_back(tl[j]);
  endtask

  always @(negedge clk) begin
    if (!resetbar) begin
      monTl.delete();
    end else if (busy) begin
      monTl.push_back(key);
      if (done) begin
        int len, diffs, first;
        bit e;
        doneCount++;
        if (expLen.size() == 0) begin
          check("unexpected_done", 1, 0);
        end else begin
          len = expLen.pop_front();
          diffs = 0;
          first = -1;
          for (int j = 0; j < len; j++) begin
            e = expBits.pop_front();
            if (j >= monTl.size() || monTl[j] != e) begin
              diffs++;
              if (first < 0) first = j;
            end
          end
          check("trace_len", monTl.size(), len);
          check("trace_diff_cycles", diffs, 0);
          if (first >= 0) $display("  first differing busy cycle %0d", first);
        end
        monTl.delete();
      end
    end
  end

  task automatic play(input logic [9:0] f, input logic [9:0] s, input int hold, input bit glitch);
    int n;
    @(negedge clk);
    FirstSeq = f;
    SecSeq = s;
    expectPlay(f, s);
    sentFlag = 1'b1;
    @(negedge clk);
    check("busy_after_load", busy, 1);
    repeat (hold - 1) @(negedge clk);
    sentFlag = 1'b0;
    if (glitch) begin
      repeat (2) @(negedge clk);
      sentFlag = 1'b1;
      @(negedge clk);
      sentFlag = 1'b0;
    end
    n = 0;
    while (busy && n < 5000) begin
      @(negedge clk);
      n++;
    end
    check("done_timeout", (n < 5000), 1);
    repeat (3) @(negedge clk);
    check("idle_after_done", busy, 0);
  endtask

  initial begin
    logic [9:0] f, s;
    int d0, n;

    #3;
    check("reset_key", key, 0);
    check("reset_busy", busy, 0);
    check("reset_done", done, 0);
    repeat (2) @(negedge clk);
    #2 resetbar = 1'b1;

    play(10'b0001111111, 10'b1111111111, 1, 0);
    play(10'b1011111111, 10'b1111111111, 1, 0);
    play(10'b0011111111, 10'b1011111111, 1, 0);
    play(10'b0101010101, 10'b1111111111, 1, 0);

    d0 = doneCount;
    play(10'b1111111111, 10'b1111111111, 100, 0);
    check("held_flag_single_done", doneCount - d0, 1);

    // Reset in the middle of the first dash of "0".
    @(negedge clk);
    FirstSeq = 10'b0101010101;
    SecSeq = 10'b1111111111;
    sentFlag = 1'b1;
    @(negedge clk);
    sentFlag = 1'b0;
    n = 0;
    while (!key && n < 50) begin
      @(negedge clk);
      n++;
    end
    repeat (5) @(negedge clk);
    check("key_before_reset", key, 1);
    #2 resetbar = 1'b0;
    #1;
    check("async_reset_key", key, 0);
    check("async_reset_busy", busy, 0);
    check("async_reset_done", done, 0);
    @(negedge clk);
    #2 resetbar = 1'b1;
    play(10'b0001111111, 10'b0011111111, 1, 0);

    for (int it = 0; it < 40; it++) begin
      f = '0;
      s = '0;
      for (int j = 0; j < 5; j++) begin
        f = {f[7:0], 2'($urandom_range(0, 3))};
        s = {s[7:0], 2'($urandom_range(0, 3))};
      end
      play(f, s, 1, (f[9:8] != 2'b11) && ($urandom_range(0, 3) == 0));
    end

    check("all_expected_played", expLen.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
